ws2812_frame_loader: RTL and testbench

- Upstream feeder for the WS2812 strip driver.
- Accepts a valid/ready RGB pixel stream and applies a global brightness scale.
- Reorders each pixel to GRB and bit-reverses it, because the driver shifts value bit 0 first. Each pixel is written into the driver's LED memory at sequential addresses.
- At frame end it pulses the driver's display input, then waits for the refresh to finish before accepting the next frame.

---
 rtl/ws2812_frame_loader.sv | 150 +++++++++++++++
 tb/tb_ws2812_frame_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_loader.sv
// Pixel-stream front end for the WS2812 driver: scales each RGB pixel by a per-frame
// brightness, reorders it to bit-reversed GRB and loads it into the driver's LED memory.
module ws2812_frame_loader #(
    parameter int unsigned NB_LEDS = 150,
    parameter int unsigned FCNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [23:0]       s_data,
    input  logic              s_last,
    input  logic [7:0]        brightness,
    input  logic              drv_busy,
    output logic              drv_write,
    output logic [31:0]       drv_addr,
    output logic [23:0]       drv_value,
    output logic              drv_display,
    output logic              frame_err,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DROP,
        ST_KICK,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        bright_q, bright_d;
    logic [31:0]       index_q, index_d;
    logic [31:0]       addr_q, addr_d;
    logic [23:0]       value_q, value_d;
    logic              pend_q, pend_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              xfer;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [8:0] k);
        logic [16:0] p;
        p = 17'(c) * 17'(k);
        return p[15:8];
    endfunction

    function automatic logic [23:0] pix_xform(input logic [23:0] px, input logic [7:0] b);
        logic [8:0]  k;
        logic [23:0] grb;
        logic [23:0] o;
        k   = {1'b0, b} + 9'd1;
        grb = {scale(px[15:8], k), scale(px[23:16], k), scale(px[7:0], k)};
        for (int unsigned i = 0; i < 24; i++) begin
            o[i] = grb[23-i];
        end
        return o;
    endfunction

    assign s_ready     = (state_q == ST_LOAD && !drv_busy) || state_q == ST_DROP
                         || state_q == ST_DRAIN;
    assign xfer        = s_valid && s_ready;
    // A pending write is dropped rather than issued once the driver reports busy.
    assign drv_write   = pend_q && !drv_busy;
    assign drv_addr    = addr_q;
    assign drv_value   = value_q;
    assign frame_cnt   = fcnt_q;

    always_comb begin
        state_d     = state_q;
        bright_d    = bright_q;
        index_d     = index_q;
        addr_d      = addr_q;
        value_d     = value_q;
        pend_d      = 1'b0;
        fcnt_d      = fcnt_q;
        drv_display = 1'b0;
        frame_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!drv_busy) begin
                    bright_d = brightness;
                    index_d  = '0;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (drv_busy) begin
                    frame_err = 1'b1;
                    state_d   = ST_DRAIN;
                end else if (xfer) begin
                    pend_d  = 1'b1;
                    addr_d  = index_q;
                    value_d = pix_xform(s_data, bright_q);
                    index_d = index_q + 32'd1;
                    if (s_last) begin
                        state_d = ST_KICK;
                    end else if (index_q == 32'(NB_LEDS - 1)) begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (xfer && s_last) begin
                    frame_err = 1'b1;
                    state_d   = ST_KICK;
                end
            end
            ST_KICK: begin
                // The last pixel's write occupies the first KICK cycle; display follows it.
                if (!pend_q) begin
                    drv_display = 1'b1;
                    fcnt_d      = fcnt_q + 1'b1;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!drv_busy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (xfer && s_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            bright_q <= '0;
            index_q  <= '0;
            addr_q   <= '0;
            value_q  <= '0;
            pend_q   <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            bright_q <= bright_d;
            index_q  <= index_d;
            addr_q   <= addr_d;
            value_q  <= value_d;
            pend_q   <= pend_d;
            fcnt_q   <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_ws2812_frame_loader.sv
// Self-checking bench for ws2812_frame_loader: transform vectors, frame-level scenarios
// and randomized frames compared against an arithmetic reference of the loader's contract.
module tb_ws2812_frame_loader;

    localparam int NB = 12;
    localparam int FW = 3;

    logic          clk;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [23:0]   s_data;
    logic          s_last;
    logic [7:0]    brightness;
    logic          drv_busy;
    logic          drv_write;
    logic [31:0]   drv_addr;
    logic [23:0]   drv_value;
    logic          drv_display;
    logic          frame_err;
    logic [FW-1:0] frame_cnt;

    ws2812_frame_loader #(.NB_LEDS(NB), .FCNT_W(FW)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .brightness(brightness),
        .drv_busy(drv_busy), .drv_write(drv_write), .drv_addr(drv_addr),
        .drv_value(drv_value), .drv_display(drv_display), .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    typedef struct {
        logic [31:0] a;
        logic [23:0] v;
    } wr_t;

    typedef struct {
        logic [23:0] px;
        logic [7:0]  b;
        logic [23:0] exp;
    } vec_t;

    int          cmp_n = 0;
    int          fail_n = 0;
    int          disp_n = 0;
    int          err_n = 0;
    int          exp_frames = 0;
    wr_t         wr_q[$];
    logic [23:0] frame_px[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] ref_f(input logic [23:0] px, input int b);
        int r, g, bl;
        logic [23:0] grb, o;
        r   = int'(px[23:16]) * (b + 1) / 256;
        g   = int'(px[15:8]) * (b + 1) / 256;
        bl  = int'(px[7:0]) * (b + 1) / 256;
        grb = 24'((g << 16) | (r << 8) | bl);
        for (int i = 0; i < 24; i++) o[i] = grb[23-i];
        return o;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            wr_t w;
            if (drv_write) begin
                w.a = drv_addr;
                w.v = drv_value;
                wr_q.push_back(w);
            end
            if (drv_display) disp_n++;
            if (frame_err) err_n++;
            chk("wr_excl", drv_write && (drv_display || drv_busy), 0);
        end
    end

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [23:0] d, input logic l);
        int t;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        t = 0;
        @(negedge clk);
        while (!s_ready && t < 300) begin
            t++;
            @(negedge clk);
        end
        if (!s_ready) chk("ready_timeout", s_ready, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_frame(input int bright, input int gap_max, input int hold);
        int n, nw, t;
        bit rdy_seen;
        n  = frame_px.size();
        nw = (n < NB) ? n : NB;
        wr_q.delete();
        disp_n = 0;
        err_n  = 0;
        brightness = 8'(bright);
        drv_busy   = 1'b0;
        for (int i = 0; i < n; i++) begin
            send(frame_px[i], i == n - 1);
            if (i == 0) brightness = 8'($urandom);
            if (i < n - 1 && gap_max > 0) idle($urandom_range(0, gap_max));
        end
        t = 0;
        while (disp_n == 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        drv_busy = 1'b1;
        rdy_seen = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (s_ready) rdy_seen = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("busy_ready", rdy_seen, 0);
        chk("wr_count", wr_q.size(), nw);
        for (int i = 0; i < wr_q.size() && i < nw; i++) begin
            chk("wr_addr", wr_q[i].a, i);
            chk("wr_value", wr_q[i].v, ref_f(frame_px[i], bright));
        end
        chk("err_cnt", err_n, (n > NB) ? 1 : 0);
        chk("disp_cnt", disp_n, 1);
        exp_frames++;
        chk("frame_cnt", frame_cnt, exp_frames % (1 << FW));
    endtask

    task automatic fill_random(input int n);
        frame_px.delete();
        for (int i = 0; i < n; i++) frame_px.push_back(24'($urandom));
    endtask

    initial begin
        vec_t vecs[9];
        logic [23:0] t5_px[$];

        vecs[0] = '{24'hFF0001, 8'd255, 24'h80FF00};
        vecs[1] = '{24'hFF0001, 8'd127, 24'h00FE00};
        vecs[2] = '{24'h000000, 8'd255, 24'h000000};
        vecs[3] = '{24'hFFFFFF, 8'd255, 24'hFFFFFF};
        vecs[4] = '{24'hFFFFFF, 8'd0,   24'h000000};
        vecs[5] = '{24'h00FF00, 8'd255, 24'h0000FF};
        vecs[6] = '{24'h0000FF, 8'd255, 24'hFF0000};
        vecs[7] = '{24'h800000, 8'd255, 24'h000100};
        vecs[8] = '{24'h808080, 8'd63,  24'h040404};

        reset = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        brightness = '0;
        drv_busy = 1'b1;

        @(posedge clk);
        #1;
        chk("rst_ready", s_ready, 0);
        chk("rst_write", drv_write, 0);
        chk("rst_addr", drv_addr, 0);
        chk("rst_value", drv_value, 0);
        chk("rst_disp", drv_display, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_cnt", frame_cnt, 0);
        idle(2);
        reset = 1'b0;
        idle(1);

        // 3-pixel frame at unity brightness
        frame_px = '{24'hFF0001, 24'hFF0001, 24'hFF0001};
        run_frame(255, 0, 4);
        for (int i = 0; i < wr_q.size(); i++) chk("t1_value", wr_q[i].v, 24'h80FF00);

        for (int i = 0; i < 9; i++) begin
            frame_px = '{vecs[i].px};
            run_frame(vecs[i].b, 0, 2);
            if (wr_q.size() > 0) chk("vec_value", wr_q[0].v, vecs[i].exp);
        end

        // Overlong frame, then exact-length frame
        fill_random(NB + 5);
        run_frame(200, 1, 3);
        fill_random(NB);
        run_frame(180, 1, 3);

        // Long busy after display, then exact restart timing
        fill_random(2);
        run_frame(255, 0, 200);
        brightness = 8'd90;
        drv_busy = 1'b0;
        @(negedge clk);
        chk("t4_n0_ready", s_ready, 0);
        @(negedge clk);
        chk("t4_n1_ready", s_ready, 0);
        @(negedge clk);
        chk("t4_n2_ready", s_ready, 1);
        @(posedge clk);
        #1;
        fill_random(3);
        run_frame(90, 1, 3);

        // Driver reset mid-frame
        wr_q.delete();
        disp_n = 0;
        err_n = 0;
        brightness = 8'd200;
        drv_busy = 1'b0;
        t5_px.delete();
        for (int i = 0; i < 10; i++) begin
            t5_px.push_back(24'($urandom));
            send(t5_px[i], 1'b0);
        end
        idle(2);
        drv_busy = 1'b1;
        for (int i = 0; i < 4; i++) send(24'($urandom), i == 3);
        idle(3);
        chk("t5_wr_count", wr_q.size(), 10);
        for (int i = 0; i < wr_q.size() && i < 10; i++) begin
            chk("t5_addr", wr_q[i].a, i);
            chk("t5_value", wr_q[i].v, ref_f(t5_px[i], 200));
        end
        chk("t5_err", err_n, 1);
        chk("t5_disp", disp_n, 0);
        chk("t5_cnt", frame_cnt, exp_frames % (1 << FW));
        fill_random(5);
        run_frame(77, 1, 2);

        // Reset right after a transfer
        brightness = 8'd255;
        drv_busy = 1'b0;
        for (int i = 0; i < 4; i++) send(24'hFFFFFF, 1'b0);
        chk("t6_pre_write", drv_write, 1);
        reset = 1'b1;
        #1;
        chk("t6_write", drv_write, 0);
        chk("t6_addr", drv_addr, 0);
        chk("t6_value", drv_value, 0);
        chk("t6_disp", drv_display, 0);
        chk("t6_err", frame_err, 0);
        chk("t6_cnt", frame_cnt, 0);
        chk("t6_ready", s_ready, 0);
        drv_busy = 1'b1;
        idle(1);
        reset = 1'b0;
        exp_frames = 0;
        @(negedge clk);
        chk("t6_idle_ready", s_ready, 0);
        @(posedge clk);
        #1;
        fill_random(2);
        run_frame(255, 1, 2);

        // Randomized frames; frame_cnt wraps along the way
        for (int f = 0; f < 10; f++) begin
            fill_random($urandom_range(1, NB + 4));
            run_frame($urandom_range(0, 255), 2, $urandom_range(1, 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule
